// File: rtl/btn_press_gen.sv
// Button-press transmitter: turns (count, short/long) commands into timed press
// waveforms on btn_o. Define BTN_GEN_ABORT_EN to add the abort_i cancel input.
module btn_press_gen #(
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned TMR_W     = 8,
   parameter int unsigned SHORT_CYC = 1,
   parameter int unsigned LONG_CYC  = 50,
   parameter int unsigned GAP_CYC   = 10
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_long_i,
   input  logic [CNT_W-1:0] cmd_count_i,
`ifdef BTN_GEN_ABORT_EN
   input  logic             abort_i,
`endif
   output logic             btn_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned TMR_MAX = (32'd1 << TMR_W) - 32'd1;
   localparam logic [TMR_W-1:0] SHORT_M1 = TMR_W'(SHORT_CYC - 32'd1);
   localparam logic [TMR_W-1:0] LONG_M1  = TMR_W'(LONG_CYC - 32'd1);
   localparam logic [TMR_W-1:0] GAP_M1   = TMR_W'(GAP_CYC - 32'd1);

   // Durations must fit the timer and be at least one cycle.
   if (SHORT_CYC < 1 || SHORT_CYC > TMR_MAX ||
       LONG_CYC  < 1 || LONG_CYC  > TMR_MAX ||
       GAP_CYC   < 1 || GAP_CYC   > TMR_MAX) begin : g_param_err
      $error("btn_press_gen: SHORT_CYC/LONG_CYC/GAP_CYC out of range 1..2**TMR_W-1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             long_q, long_d;
   logic             btn_q, busy_q, done_q, done_d;
   logic [TMR_W-1:0] len_m1;

   assign cmd_ready_o = (state_q == IDLE);
   assign btn_o       = btn_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

   // Next-state logic: timer counts len-1..0 per phase, rem counts presses left.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rem_d   = rem_q;
      long_d  = long_q;
      done_d  = 1'b0;
      len_m1  = long_q ? LONG_M1 : SHORT_M1;

      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               long_d = cmd_long_i;
               rem_d  = cmd_count_i;
               if (cmd_count_i != '0) begin
                  state_d = PRESS;
                  timer_d = cmd_long_i ? LONG_M1 : SHORT_M1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         PRESS: begin
            if (timer_q == '0) begin
               state_d = GAP;
               timer_d = GAP_M1;
               rem_d   = rem_q - CNT_W'(1);
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         GAP: begin
            if (timer_q == '0) begin
               if (rem_q != '0) begin
                  state_d = PRESS;
                  timer_d = len_m1;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef BTN_GEN_ABORT_EN
      // Abort overrides timer expiry but never an accept in IDLE.
      if (abort_i && (state_q != IDLE)) begin
         state_d = IDLE;
         timer_d = '0;
         rem_d   = '0;
         done_d  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         timer_q <= '0;
         rem_q   <= '0;
         long_q  <= 1'b0;
         btn_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         rem_q   <= rem_d;
         long_q  <= long_d;
         btn_q   <= (state_d == PRESS);
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_btn_press_gen.sv
// Self-checking bench for btn_press_gen: vector table, hand-written corner
// sequences and random commands against a waveform-level reference model.
module tb_btn_press_gen;

   localparam int unsigned CNT_W     = 4;
   localparam int unsigned TMR_W     = 8;
   localparam int unsigned SHORT_CYC = 1;
   localparam int unsigned LONG_CYC  = 50;
   localparam int unsigned GAP_CYC   = 10;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_long = 1'b0;
   logic [CNT_W-1:0] cmd_count = '0;
   logic             cmd_ready, btn, busy, done;
`ifdef BTN_GEN_ABORT_EN
   logic             abort = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5ns clk = ~clk;

   btn_press_gen #(
      .CNT_W(CNT_W), .TMR_W(TMR_W), .SHORT_CYC(SHORT_CYC),
      .LONG_CYC(LONG_CYC), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_long_i  (cmd_long),
      .cmd_count_i (cmd_count),
`ifdef BTN_GEN_ABORT_EN
      .abort_i     (abort),
`endif
      .btn_o       (btn),
      .busy_o      (busy),
      .done_o      (done)
   );

   typedef struct {
      bit lng;
      int cnt;
      int exp_lat;
      int exp_high;
      int exp_rises;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1ns;
   endtask

   task automatic wait_ready(output bit ok);
      int n;
      n  = 0;
      ok = 1'b1;
      while (cmd_ready !== 1'b1) begin
         step();
         n++;
         if (n > 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: cmd_ready still %b after %0d cycles, expected 1", cmd_ready, n);
            ok = 1'b0;
            return;
         end
      end
   endtask

   // Reference model: the whole expected waveform is laid out as a queue of
   // {btn,busy,done} per cycle from the press/gap lengths, then compared.
   task automatic run_cmd(input bit lng, input int cnt, input bit nxt_v, input bit nxt_l, input int nxt_c);
      bit         ok;
      int         len;
      logic [2:0] q[$];
      logic [2:0] e;
      cmd_valid = 1'b1;
      cmd_long  = lng;
      cmd_count = CNT_W'(cnt);
      wait_ready(ok);
      if (!ok) return;
      step();
      cmd_valid = nxt_v;
      cmd_long  = nxt_l;
      cmd_count = CNT_W'(nxt_c);
      len = lng ? int'(LONG_CYC) : int'(SHORT_CYC);
      for (int p = 0; p < cnt; p++) begin
         repeat (len) q.push_back(3'b110);
         repeat (GAP_CYC) q.push_back(3'b010);
      end
      q.push_back(3'b001);
      while (q.size() > 0) begin
         e = q.pop_front();
         n_tests++;
         if ({btn, busy, done} !== e || cmd_ready !== ~e[1]) begin
            n_fail++;
            if (n_fail < 20)
               $display("FAIL model(long=%0d cnt=%0d): btn/busy/done/ready=%b%b%b%b, expected %b%b%b%b",
                        lng, cnt, btn, busy, done, cmd_ready, e[2], e[1], e[0], ~e[1]);
         end
         if (q.size() > 0) step();
      end
   endtask

   // Measures one command from the outside and compares against the table.
   task automatic measure(input int idx);
      vec_t v;
      int   lat, highs, rises, rdy_bad;
      logic prev;
      bit   ok;
      v = vecs[idx];
      cmd_valid = 1'b1;
      cmd_long  = v.lng;
      cmd_count = CNT_W'(v.cnt);
      wait_ready(ok);
      if (!ok) return;
      step();
      cmd_valid = 1'b0;
      lat = 1; highs = 0; rises = 0; rdy_bad = 0; prev = 1'b0;
      while (done !== 1'b1 && lat < 4000) begin
         if (btn === 1'b1) highs++;
         if (btn === 1'b1 && prev !== 1'b1) rises++;
         prev = btn;
         if (cmd_ready !== 1'b0) rdy_bad++;
         step();
         lat++;
      end
      check($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.exp_lat));
      check($sformatf("vec%0d high cycles", idx), 32'(highs), 32'(v.exp_high));
      check($sformatf("vec%0d presses", idx), 32'(rises), 32'(v.exp_rises));
      check($sformatf("vec%0d ready while busy", idx), 32'(rdy_bad), 32'd0);
      check($sformatf("vec%0d busy at done", idx), 32'(busy), 32'd0);
      check($sformatf("vec%0d ready at done", idx), 32'(cmd_ready), 32'd1);
      check($sformatf("vec%0d btn at done", idx), 32'(btn), 32'd0);
      step();
      check($sformatf("vec%0d done width", idx), 32'(done), 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   ok;
      logic b_hist[48];
      logic d_hist[48];
      int   d1, d2, last_hi, cl, cc, nl, nc, highs;
      bit   pl, dropped;

      vecs[0] = '{1'b0, 1, 12, 1, 1};
      vecs[1] = '{1'b1, 2, 121, 100, 2};
      vecs[2] = '{1'b0, 0, 1, 0, 0};
      vecs[3] = '{1'b0, 3, 34, 3, 3};
      vecs[4] = '{1'b1, 1, 61, 50, 1};
      vecs[5] = '{1'b0, 15, 166, 15, 15};

      // Reset state
      #12ns;
      check("in reset btn", 32'(btn), 32'd0);
      check("in reset busy", 32'(busy), 32'd0);
      check("in reset done", 32'(done), 32'd0);
      #10ns reset_n = 1'b1;
      step();
      check("post reset ready", 32'(cmd_ready), 32'd1);
      check("post reset busy", 32'(busy), 32'd0);
      check("post reset done", 32'(done), 32'd0);

      foreach (vecs[i]) measure(i);

      // Async reset in the middle of a long press cuts btn off at once
      cmd_valid = 1'b1; cmd_long = 1'b1; cmd_count = CNT_W'(2);
      wait_ready(ok);
      step();
      cmd_valid = 1'b0;
      repeat (10) step();
      check("mid press btn", 32'(btn), 32'd1);
      #3ns reset_n = 1'b0;
      #1ns;
      check("async reset btn", 32'(btn), 32'd0);
      check("async reset busy", 32'(busy), 32'd0);
      #20ns reset_n = 1'b1;
      step();
      check("after reset ready", 32'(cmd_ready), 32'd1);
      check("after reset busy", 32'(busy), 32'd0);
      check("after reset done", 32'(done), 32'd0);
      highs = 0;
      repeat (60) begin
         step();
         if (btn !== 1'b0) highs++;
      end
      check("no press after reset", 32'(highs), 32'd0);

      // Back-to-back: second command held valid during the first
      cmd_valid = 1'b1; cmd_long = 1'b0; cmd_count = CNT_W'(2);
      wait_ready(ok);
      step();
      cmd_count = CNT_W'(1);
      dropped = 1'b0;
      for (int i = 0; i < 48; i++) begin
         b_hist[i] = btn;
         d_hist[i] = done;
         step();
         if (d_hist[i] === 1'b1 && !dropped) begin
            cmd_valid = 1'b0;
            dropped = 1'b1;
         end
      end
      d1 = -1; d2 = -1; last_hi = -1;
      for (int i = 0; i < 48; i++) begin
         if (d_hist[i] === 1'b1) begin
            if (d1 < 0) d1 = i;
            else if (d2 < 0) d2 = i;
         end
         if (b_hist[i] === 1'b1 && d1 < 0) last_hi = i;
      end
      check("b2b first done", 32'(d1), 32'd22);
      check("b2b second done", 32'(d2), 32'(d1 + int'(SHORT_CYC + GAP_CYC) + 1));
      check("b2b rise after done", 32'((d1 >= 0 && d1 < 47) ? b_hist[d1 + 1] : 1'b0), 32'd1);
      // Low run spans the gap plus the done cycle in which the next command is taken.
      check("b2b low run", 32'(d1 + 1 - last_hi - 1), 32'(GAP_CYC + 1));
      step();

`ifdef BTN_GEN_ABORT_EN
      // Abort 20 cycles into a long press of count=3
      cmd_valid = 1'b1; cmd_long = 1'b1; cmd_count = CNT_W'(3);
      wait_ready(ok);
      step();
      cmd_valid = 1'b0;
      repeat (19) step();
      check("abort pre btn", 32'(btn), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort btn", 32'(btn), 32'd0);
      check("abort done", 32'(done), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      check("abort ready", 32'(cmd_ready), 32'd1);
      highs = 0;
      repeat (80) begin
         step();
         if (btn !== 1'b0 || done !== 1'b0) highs++;
      end
      check("abort no further activity", 32'(highs), 32'd0);
      // Abort in IDLE is ignored
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("idle abort done", 32'(done), 32'd0);
      // Abort together with accept: the accept wins
      cmd_valid = 1'b1; cmd_long = 1'b0; cmd_count = CNT_W'(2); abort = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("accept beats abort btn", 32'(btn), 32'd1);
      check("accept beats abort done", 32'(done), 32'd0);
      // Abort on the last press cycle beats the timer expiry
      step();
      abort = 1'b0;
      check("abort over expiry done", 32'(done), 32'd1);
      check("abort over expiry busy", 32'(busy), 32'd0);
      step();
`endif

      // Random commands, optionally preloaded while the previous one runs
      cl = int'($urandom_range(0, 1));
      cc = (cl != 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15));
      for (int k = 0; k < 40; k++) begin
         nl = int'($urandom_range(0, 1));
         nc = (nl != 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15));
         pl = ($urandom_range(0, 1) == 1);
         run_cmd(cl[0], cc, pl, nl[0], nc);
         if (!pl) repeat ($urandom_range(0, 3)) step();
         cl = nl;
         cc = nc;
      end
      cmd_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
